// File: rtl/lsu_icb_ctrl_if.sv
// AGU-side ICB command/response and memory-side command/response bundle for lsu_icb_ctrl.
// slave = LSU view, master = execute-stage/memory environment view.
interface lsu_icb_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            agu_icb_cmd_valid;
  logic            agu_icb_cmd_ready;
  logic [AW-1:0]   agu_icb_cmd_addr;
  logic            agu_icb_cmd_read;
  logic [DW-1:0]   agu_icb_cmd_wdata;
  logic [DW/8-1:0] agu_icb_cmd_wmask;
  logic            agu_icb_rsp_valid;
  logic            agu_icb_rsp_ready;
  logic [DW-1:0]   agu_icb_rsp_rdata;
  logic            agu_icb_rsp_err;
  logic            mem_cmd_valid;
  logic            mem_cmd_ready;
  logic [AW-1:0]   mem_cmd_addr;
  logic            mem_cmd_read;
  logic [DW-1:0]   mem_cmd_wdata;
  logic [DW/8-1:0] mem_cmd_wmask;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_rdata;
  logic            mem_rsp_err;
  logic            lsu_busy;

  modport slave (
    input  agu_icb_cmd_valid, agu_icb_cmd_addr, agu_icb_cmd_read, agu_icb_cmd_wdata,
           agu_icb_cmd_wmask, agu_icb_rsp_ready, mem_cmd_ready, mem_rsp_valid,
           mem_rsp_rdata, mem_rsp_err,
    output agu_icb_cmd_ready, agu_icb_rsp_valid, agu_icb_rsp_rdata, agu_icb_rsp_err,
           mem_cmd_valid, mem_cmd_addr, mem_cmd_read, mem_cmd_wdata, mem_cmd_wmask,
           lsu_busy
  );

  modport master (
    output agu_icb_cmd_valid, agu_icb_cmd_addr, agu_icb_cmd_read, agu_icb_cmd_wdata,
           agu_icb_cmd_wmask, agu_icb_rsp_ready, mem_cmd_ready, mem_rsp_valid,
           mem_rsp_rdata, mem_rsp_err,
    input  agu_icb_cmd_ready, agu_icb_rsp_valid, agu_icb_rsp_rdata, agu_icb_rsp_err,
           mem_cmd_valid, mem_cmd_addr, mem_cmd_read, mem_cmd_wdata, mem_cmd_wmask,
           lsu_busy
  );
endinterface

// File: rtl/lsu_icb_ctrl.sv
// Single-outstanding LSU: one AGU command -> one memory transaction -> one LSB-aligned response.
// Latency 3 cycles cmd-to-rsp with zero-wait memory; LSU_TIMEOUT_EN adds a WAIT-state error timeout.
module lsu_icb_ctrl #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_icb_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   addr_q;
  logic            read_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wmask_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic            timeout;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state == CMD && bus.mem_cmd_ready) begin
      cnt_q <= '0;
    end else if (state == WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A response arriving on the limit cycle takes priority over the timeout.
  assign timeout = (state == WAIT) && !bus.mem_rsp_valid && (cnt_q == CW'(TIMEOUT_CYC));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.agu_icb_cmd_valid) state_nxt = CMD;
      CMD:     if (bus.mem_cmd_ready) state_nxt = WAIT;
      WAIT:    if (bus.mem_rsp_valid || timeout) state_nxt = RSP;
      RSP:     if (bus.agu_icb_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      read_q  <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.agu_icb_cmd_valid) begin
        addr_q  <= bus.agu_icb_cmd_addr;
        read_q  <= bus.agu_icb_cmd_read;
        wdata_q <= bus.agu_icb_cmd_wdata;
        wmask_q <= bus.agu_icb_cmd_read ? '0 : bus.agu_icb_cmd_wmask;
      end
      if (state == WAIT) begin
        if (bus.mem_rsp_valid) begin
          err_q   <= bus.mem_rsp_err;
          rdata_q <= read_q ? (bus.mem_rsp_rdata >> {addr_q[1:0], 3'b000}) : '0;
        end else if (timeout) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  assign bus.agu_icb_cmd_ready = (state == IDLE);
  assign bus.mem_cmd_valid     = (state == CMD);
  assign bus.agu_icb_rsp_valid = (state == RSP);
  assign bus.lsu_busy          = (state != IDLE);
  assign bus.mem_cmd_addr      = {addr_q[AW-1:2], 2'b00};
  assign bus.mem_cmd_read      = read_q;
  assign bus.mem_cmd_wdata     = wdata_q;
  assign bus.mem_cmd_wmask     = wmask_q;
  assign bus.agu_icb_rsp_rdata = rdata_q;
  assign bus.agu_icb_rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_icb_ctrl.sv
// Directed + randomized bench for lsu_icb_ctrl against an arithmetic reference of the load/store rules.
module tb_lsu_icb_ctrl;
  localparam int TOUT = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;

  lsu_icb_ctrl_if #(.AW(32), .DW(32)) bus ();

  lsu_icb_ctrl #(.AW(32), .DW(32), .TIMEOUT_CYC(TOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [31:0] a, input bit rd, input logic [31:0] wd, input logic [3:0] wm);
    bus.agu_icb_cmd_valid = 1'b1;
    bus.agu_icb_cmd_addr  = a;
    bus.agu_icb_cmd_read  = rd;
    bus.agu_icb_cmd_wdata = wd;
    bus.agu_icb_cmd_wmask = wm;
  endtask

  task automatic scramble_cmd();
    bus.agu_icb_cmd_addr  = $urandom;
    bus.agu_icb_cmd_read  = 1'($urandom);
    bus.agu_icb_cmd_wdata = $urandom;
    bus.agu_icb_cmd_wmask = 4'($urandom);
  endtask

  // One full transaction; cdly/rdly/hdly are memory-accept, memory-response and AGU-accept stalls.
  task automatic do_txn(input logic [31:0] a, input bit rd, input logic [31:0] wd, input logic [3:0] wm,
                        input int cdly, input int rdly, input int hdly,
                        input logic [31:0] raw, input bit er, input bit push_next);
    int hs;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_mask;
    exp_addr  = a & ~32'h3;
    exp_rdata = rd ? (raw / (32'h1 << (8 * int'(a % 4)))) : 32'h0;
    exp_mask  = rd ? 4'h0 : wm;

    drive_cmd(a, rd, wd, wm);
    check("cmd_ready_idle", bus.agu_icb_cmd_ready, 1);
    tick();
    hs = cyc;
    bus.agu_icb_cmd_valid = 1'b0;
    scramble_cmd();
    for (int i = 0; i <= cdly; i++) begin
      check("mem_cmd_valid", bus.mem_cmd_valid, 1);
      check("mem_cmd_addr", bus.mem_cmd_addr, exp_addr);
      check("mem_cmd_read", bus.mem_cmd_read, rd);
      check("mem_cmd_wdata", bus.mem_cmd_wdata, wd);
      check("mem_cmd_wmask", bus.mem_cmd_wmask, exp_mask);
      check("cmd_ready_busy", bus.agu_icb_cmd_ready, 0);
      if (i == cdly) bus.mem_cmd_ready = 1'b1;
      tick();
    end
    bus.mem_cmd_ready = 1'b0;
    for (int i = 0; i <= rdly; i++) begin
      check("wait_no_mem_cmd", bus.mem_cmd_valid, 0);
      check("wait_no_rsp", bus.agu_icb_rsp_valid, 0);
      check("wait_busy", bus.lsu_busy, 1);
      if (i == rdly) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = raw;
        bus.mem_rsp_err   = er;
      end
      tick();
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = $urandom;
    bus.mem_rsp_err   = 1'($urandom);
    check("latency", cyc - hs, cdly + rdly + 2);
    for (int i = 0; i <= hdly; i++) begin
      check("rsp_valid", bus.agu_icb_rsp_valid, 1);
      check("rsp_rdata", bus.agu_icb_rsp_rdata, exp_rdata);
      check("rsp_err", bus.agu_icb_rsp_err, er);
      check("cmd_ready_rsp", bus.agu_icb_cmd_ready, 0);
      if (push_next) begin
        drive_cmd($urandom, 1'($urandom), $urandom, 4'($urandom));
      end
      if (i == hdly) bus.agu_icb_rsp_ready = 1'b1;
      tick();
    end
    bus.agu_icb_rsp_ready = 1'b0;
    check("rsp_done_valid", bus.agu_icb_rsp_valid, 0);
    check("rsp_done_idle", bus.lsu_busy, 0);
    check("rsp_done_ready", bus.agu_icb_cmd_ready, 1);
  endtask

  // Issue a load and leave the DUT sitting in WAIT.
  task automatic enter_wait(input logic [31:0] a);
    drive_cmd(a, 1'b1, 32'h0, 4'h0);
    tick();
    bus.agu_icb_cmd_valid = 1'b0;
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", bus.lsu_busy, 0);
    check("rst_cmd_ready", bus.agu_icb_cmd_ready, 1);
    check("rst_mem_cmd_valid", bus.mem_cmd_valid, 0);
    check("rst_rsp_valid", bus.agu_icb_rsp_valid, 0);
    check("rst_mem_cmd_addr", bus.mem_cmd_addr, 0);
    check("rst_rsp_rdata", bus.agu_icb_rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int waited;
    int idle_seen;
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus.agu_icb_cmd_valid = 1'b0;
    bus.agu_icb_cmd_addr  = '0;
    bus.agu_icb_cmd_read  = 1'b0;
    bus.agu_icb_cmd_wdata = '0;
    bus.agu_icb_cmd_wmask = '0;
    bus.agu_icb_rsp_ready = 1'b0;
    bus.mem_cmd_ready     = 1'b0;
    bus.mem_rsp_valid     = 1'b0;
    bus.mem_rsp_rdata     = '0;
    bus.mem_rsp_err       = 1'b0;
    #12;
    check("reset_cmd_ready", bus.agu_icb_cmd_ready, 1);
    check("reset_busy", bus.lsu_busy, 0);
    check("reset_mem_cmd_valid", bus.mem_cmd_valid, 0);
    check("reset_rsp_valid", bus.agu_icb_rsp_valid, 0);
    check("reset_wdata", bus.mem_cmd_wdata, 0);
    check("reset_err", bus.agu_icb_rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Misaligned load, zero-wait memory.
    do_txn(32'h8000_0006, 1'b1, 32'h0, 4'h0, 0, 0, 0, 32'hAABB_CCDD, 1'b0, 1'b0);
    // Store with memory accepting after 3 stalled cycles.
    do_txn(32'h0000_0100, 1'b0, 32'h1234_5678, 4'b1100, 3, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    // AGU stalls the response 5 cycles while a second command waits.
    do_txn(32'h0000_0203, 1'b1, 32'h0, 4'h0, 0, 1, 5, 32'h1122_3344, 1'b0, 1'b1);
    // Load with a bus error.
    do_txn(32'h0000_0011, 1'b1, 32'h0, 4'h0, 1, 2, 0, 32'hCAFE_F00D, 1'b1, 1'b0);

    // Stray memory response while idle.
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'hFFFF_FFFF;
    tick();
    bus.mem_rsp_valid = 1'b0;
    tick();
    check("stray_busy", bus.lsu_busy, 0);
    check("stray_rsp_valid", bus.agu_icb_rsp_valid, 0);
    check("stray_cmd_ready", bus.agu_icb_cmd_ready, 1);

    // Asynchronous reset while waiting on memory, then a late memory response.
    enter_wait(32'h0000_0040);
    check("pre_rst_busy", bus.lsu_busy, 1);
    do_reset();
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    tick();
    check("post_rst_rsp_valid", bus.agu_icb_rsp_valid, 0);
    check("post_rst_busy", bus.lsu_busy, 0);

    for (int n = 0; n < 40; n++) begin
      do_txn($urandom, 1'($urandom), $urandom, 4'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom, ($urandom_range(0, 7) == 0), 1'b0);
    end

    // Memory never responds.
    enter_wait(32'h0000_0082);
    waited = 0;
    idle_seen = 0;
`ifdef LSU_TIMEOUT_EN
    while (!bus.agu_icb_rsp_valid && waited < 100) begin
      waited++;
      tick();
    end
    check("timeout_fired", bus.agu_icb_rsp_valid, 1);
    check("timeout_window", (waited >= TOUT && waited <= TOUT + 1), 1);
    check("timeout_err", bus.agu_icb_rsp_err, 1);
    check("timeout_rdata", bus.agu_icb_rsp_rdata, 0);
    bus.agu_icb_rsp_ready = 1'b1;
    tick();
    bus.agu_icb_rsp_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    tick();
    check("late_rsp_ignored", bus.agu_icb_rsp_valid, 0);
    check("late_rsp_idle", bus.lsu_busy, 0);
`else
    for (int i = 0; i < 1000; i++) begin
      if (!bus.lsu_busy || bus.agu_icb_rsp_valid) idle_seen++;
      waited++;
      tick();
    end
    check("hold_wait_cycles", waited, 1000);
    check("hold_wait_busy", idle_seen, 0);
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
